// File: rtl/i2c_pkg.sv
// Shared types for the codec configuration sequencer: FSM encoding, I2C write bit,
// and the 16-bit {reg, data} configuration word layout.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StWStart,
    StAddr,
    StWAddr,
    StHi,
    StWHi,
    StLo,
    StWLo,
    StStop,
    StWStop,
    StGap,
    StNack,
    StWNack
  } state_e;

  localparam logic I2C_WRITE_BIT = 1'b0;

  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } cfg_word_t;

  function automatic cfg_word_t make_word(input logic [6:0] reg_addr, input logic [8:0] data);
    cfg_word_t w;
    w.reg_addr = reg_addr;
    w.data     = data;
    return w;
  endfunction

endpackage

// File: rtl/i2c_config_sequencer_if.sv
// Command/response bus between the configuration sequencer and the byte-level I2C engine.
interface i2c_config_sequencer_if;
  logic       eng_start;
  logic       eng_write;
  logic       eng_stop;
  logic [7:0] eng_byte;
  logic       eng_done;
  logic       eng_ack;

  modport master (
    output eng_start, eng_write, eng_stop, eng_byte,
    input  eng_done, eng_ack
  );

  modport slave (
    input  eng_start, eng_write, eng_stop, eng_byte,
    output eng_done, eng_ack
  );
endinterface

// File: rtl/i2c_config_rom.sv
// Codec register table: index -> {reg[6:0], data[8:0]}. Unused slots read as zero.
module i2c_config_rom
  import i2c_pkg::*;
(
  input  logic [3:0]  index_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = '0;
    case (index_i)
      4'd0:    word_o = make_word(7'h0F, 9'h000);  // soft reset
      4'd1:    word_o = make_word(7'h06, 9'h010);
      4'd2:    word_o = make_word(7'h00, 9'h017);
      4'd3:    word_o = make_word(7'h01, 9'h017);
      4'd4:    word_o = make_word(7'h02, 9'h079);
      4'd5:    word_o = make_word(7'h03, 9'h079);
      4'd6:    word_o = make_word(7'h04, 9'h012);
      4'd7:    word_o = make_word(7'h05, 9'h000);
      4'd8:    word_o = make_word(7'h07, 9'h00A);
      4'd9:    word_o = make_word(7'h09, 9'h001);  // activate last
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the codec register table, sending each word as a 3-byte I2C write with bounded
// NACK retry, and reports done/error to the init controller.
module i2c_config_sequencer
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned NUM_REGS   = 10,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 250
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go_i,
  i2c_config_sequencer_if.master eng,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [3:0]             cur_index_o
);

  localparam int unsigned GapW   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [GapW-1:0]   GapLast  = GapW'(((GAP_CYCLES > 0) ? GAP_CYCLES : 1) - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [3:0]        LastIdx  = 4'(NUM_REGS - 1);
  localparam bit                NoGap    = (GAP_CYCLES == 0);

  state_e              state_q;
  logic [3:0]          index_q;
  logic [RetryW-1:0]   retry_q;
  logic [GapW-1:0]     gap_q;
  logic                start_q, write_q, stop_q;
  logic [7:0]          byte_q;
  logic                busy_q, done_q, error_q;
  logic [15:0]         word;
  logic                done_seen;

  i2c_config_rom u_rom (
    .index_i (index_q),
    .word_o  (word)
  );

  // A done arriving while our own command pulse is still on the bus cannot belong to it.
  assign done_seen = eng.eng_done & ~(start_q | write_q | stop_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      index_q <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      start_q <= 1'b0;
      write_q <= 1'b0;
      stop_q  <= 1'b0;
      byte_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      write_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            index_q <= '0;
            retry_q <= '0;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          start_q <= 1'b1;
          state_q <= StWStart;
        end
        StWStart: if (done_seen) state_q <= StAddr;
        StAddr: begin
          byte_q  <= {DEV_ADDR, I2C_WRITE_BIT};
          write_q <= 1'b1;
          state_q <= StWAddr;
        end
        StWAddr: if (done_seen) state_q <= eng.eng_ack ? StHi : StNack;
        StHi: begin
          byte_q  <= word[15:8];
          write_q <= 1'b1;
          state_q <= StWHi;
        end
        StWHi: if (done_seen) state_q <= eng.eng_ack ? StLo : StNack;
        StLo: begin
          byte_q  <= word[7:0];
          write_q <= 1'b1;
          state_q <= StWLo;
        end
        StWLo: if (done_seen) state_q <= eng.eng_ack ? StStop : StNack;
        StStop: begin
          stop_q  <= 1'b1;
          state_q <= StWStop;
        end
        StWStop: begin
          if (done_seen) begin
            if (index_q == LastIdx) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              index_q <= index_q + 4'd1;
              retry_q <= '0;
              gap_q   <= '0;
              // START goes out exactly GAP_CYCLES+1 cycles after the STOP completes.
              if (NoGap) begin
                start_q <= 1'b1;
                state_q <= StWStart;
              end else begin
                state_q <= StGap;
              end
            end
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            start_q <= 1'b1;
            state_q <= StWStart;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        StNack: begin
          stop_q  <= 1'b1;
          state_q <= StWNack;
        end
        StWNack: begin
          if (done_seen) begin
            if (retry_q < RetryMax) begin
              retry_q <= retry_q + 1'b1;
              gap_q   <= '0;
              if (NoGap) begin
                start_q <= 1'b1;
                state_q <= StWStart;
              end else begin
                state_q <= StGap;
              end
            end else begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng.eng_start = start_q;
  assign eng.eng_write = write_q;
  assign eng.eng_stop  = stop_q;
  assign eng.eng_byte  = byte_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign cur_index_o   = index_q;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench: behavioural I2C byte engine with programmable NACKs, command log and
// per-scenario expected command streams.
module tb_i2c_config_sequencer;

  localparam int Lat = 3;
  localparam int Gap = 250;

  logic       clk;
  logic       reset;
  logic       go;
  logic       busy, done, error;
  logic [3:0] cur_index;

  i2c_config_sequencer_if bus ();

  i2c_config_sequencer #(
    .DEV_ADDR   (7'h1A),
    .NUM_REGS   (10),
    .MAX_RETRY  (3),
    .GAP_CYCLES (Gap)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go_i        (go),
    .eng         (bus),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .cur_index_o (cur_index)
  );

  int checks = 0;
  int errors = 0;

  // Engine model / monitor state
  int         cyc = 0;
  int         trans_cnt, wpos, cnt, pend_kind;
  bit         pend;
  logic [7:0] pend_byte;
  logic       pend_ack;
  int         unstable = 0, overlap = 0, done_cnt = 0, last_lo_trans = -1, go_cyc = 0;
  int         nack_trans = -1, nack_pos = -1, nack_left = 0;
  bit         nack_addr_all = 0;
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];
  int         start_cyc[$];
  int         stop_done_cyc[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] exp_word(input int i);
    case (i)
      0: return 16'h1E00;
      1: return 16'h0C10;
      2: return 16'h0017;
      3: return 16'h0217;
      4: return 16'h0479;
      5: return 16'h0679;
      6: return 16'h0812;
      7: return 16'h0A00;
      8: return 16'h0E0A;
      9: return 16'h1201;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    bus.eng_done = 1'b0;
    bus.eng_ack  = 1'b0;
    pend = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.eng_done = 1'b0;
      bus.eng_ack  = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (pend_kind == 2 && bus.eng_byte !== pend_byte) unstable++;
          cnt--;
          if (cnt == 0) begin
            bus.eng_done = 1'b1;
            bus.eng_ack  = pend_ack;
            pend = 0;
            if (pend_kind == 3) stop_done_cyc.push_back(cyc);
          end
        end
        if (bus.eng_start || bus.eng_write || bus.eng_stop) begin
          if (pend || (int'(bus.eng_start) + int'(bus.eng_write) + int'(bus.eng_stop) > 1))
            overlap++;
          pend = 1;
          cnt  = Lat;
          pend_ack = 1'b0;
          if (bus.eng_start) begin
            pend_kind = 1;
            trans_cnt++;
            wpos = 0;
            start_cyc.push_back(cyc);
            log_q.push_back({2'd1, 8'h00});
          end else if (bus.eng_write) begin
            pend_kind = 2;
            pend_byte = bus.eng_byte;
            pend_ack  = 1'b1;
            if (nack_addr_all && wpos == 0) pend_ack = 1'b0;
            if (nack_left > 0 && trans_cnt - 1 == nack_trans && wpos == nack_pos) begin
              pend_ack = 1'b0;
              nack_left--;
            end
            if (wpos == 2) last_lo_trans = trans_cnt - 1;
            wpos++;
            log_q.push_back({2'd2, bus.eng_byte});
          end else begin
            pend_kind = 3;
            log_q.push_back({2'd3, 8'h00});
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic clear_logs();
    log_q.delete();
    exp_q.delete();
    start_cyc.delete();
    stop_done_cyc.delete();
    trans_cnt = 0;
  endtask

  task automatic push_txn(input int idx);
    logic [15:0] w;
    w = exp_word(idx);
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h34});
    exp_q.push_back({2'd2, w[15:8]});
    exp_q.push_back({2'd2, w[7:0]});
    exp_q.push_back({2'd3, 8'h00});
  endtask

  task automatic drive_go();
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_log(input string name);
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s log length: got %0d, required %0d", name, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cmd[%0d]: got %h, required %h", name, i, log_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [15:0] got;
    got = {busy, done, error, cur_index, bus.eng_start, bus.eng_write, bus.eng_stop, 1'b0,
           bus.eng_byte[3:0]};
    checks++;
    if (got !== 16'h0000 || bus.eng_byte !== 8'h00) begin
      errors++;
      $display("FAIL %s outputs: busy=%b done=%b error=%b idx=%h st=%b wr=%b sp=%b byte=%h, required all 0",
               name, busy, done, error, cur_index, bus.eng_start, bus.eng_write, bus.eng_stop,
               bus.eng_byte);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("after_reset");
  endtask

  task automatic test_all_ack();
    int d0;
    clear_logs();
    for (int i = 0; i < 10; i++) push_txn(i);
    d0 = done_cnt;
    drive_go();
    wait_idle("all_ack");
    check_log("all_ack");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL all_ack done pulses: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL all_ack error: got %b, required 0", error);
    end
    checks++;
    if (cur_index !== 4'd9) begin
      errors++;
      $display("FAIL all_ack cur_index: got %0d, required 9", cur_index);
    end
  endtask

  task automatic test_gap_timing();
    int u0, o0;
    clear_logs();
    u0 = unstable;
    o0 = overlap;
    drive_go();
    wait_idle("gap");
    checks++;
    if (start_cyc.size() < 1 || start_cyc[0] - go_cyc != 2) begin
      errors++;
      $display("FAIL go_latency: got %0d, required 2",
               start_cyc.size() > 0 ? start_cyc[0] - go_cyc : -1);
    end
    for (int k = 0; k < 9 && k + 1 < start_cyc.size() && k < stop_done_cyc.size(); k++) begin
      checks++;
      if (start_cyc[k+1] - stop_done_cyc[k] != Gap + 1) begin
        errors++;
        $display("FAIL gap[%0d]: got %0d cycles, required %0d", k,
                 start_cyc[k+1] - stop_done_cyc[k], Gap + 1);
      end
    end
    checks++;
    if (unstable - u0 != 0) begin
      errors++;
      $display("FAIL byte_stable: got %0d unstable cycles, required 0", unstable - u0);
    end
    checks++;
    if (overlap - o0 != 0) begin
      errors++;
      $display("FAIL one_outstanding: got %0d overlaps, required 0", overlap - o0);
    end
  endtask

  task automatic test_nack_retry();
    int d0;
    logic [15:0] w3;
    clear_logs();
    w3 = exp_word(3);
    for (int i = 0; i < 3; i++) push_txn(i);
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h34});
    exp_q.push_back({2'd2, w3[15:8]});
    exp_q.push_back({2'd3, 8'h00});
    for (int i = 3; i < 10; i++) push_txn(i);
    nack_trans = 3;
    nack_pos   = 1;
    nack_left  = 1;
    d0 = done_cnt;
    drive_go();
    wait_idle("nack_retry");
    check_log("nack_retry");
    checks++;
    if (trans_cnt != 11) begin
      errors++;
      $display("FAIL nack_retry transactions: got %0d, required 11", trans_cnt);
    end
    checks++;
    if (done_cnt - d0 != 1 || error !== 1'b0) begin
      errors++;
      $display("FAIL nack_retry status: done pulses %0d error %b, required 1 and 0",
               done_cnt - d0, error);
    end
    nack_left = 0;
  endtask

  task automatic test_addr_abort();
    int d0;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'd1, 8'h00});
      exp_q.push_back({2'd2, 8'h34});
      exp_q.push_back({2'd3, 8'h00});
    end
    nack_addr_all = 1;
    d0 = done_cnt;
    drive_go();
    wait_idle("addr_abort");
    check_log("addr_abort");
    checks++;
    if (error !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL addr_abort status: error=%b busy=%b, required 1 and 0", error, busy);
    end
    checks++;
    if (done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL addr_abort done pulses: got %0d, required 0", done_cnt - d0);
    end
    nack_addr_all = 0;
  endtask

  task automatic test_go_while_busy();
    int d0, n;
    clear_logs();
    for (int i = 0; i < 10; i++) push_txn(i);
    d0 = done_cnt;
    drive_go();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || cur_index !== 4'd0) begin
      errors++;
      $display("FAIL restart_after_error: error=%b busy=%b idx=%0d, required 0 1 0",
               error, busy, cur_index);
    end
    n = 0;
    while (trans_cnt < 3 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    drive_go();
    wait_idle("go_busy");
    check_log("go_busy");
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL go_busy done pulses: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    last_lo_trans = -1;
    drive_go();
    while (last_lo_trans != 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (last_lo_trans != 5) begin
      errors++;
      $display("FAIL reset_mid reach W_LO: got trans %0d, required 5", last_lo_trans);
    end
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("reset_mid");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_outputs_zero("reset_mid_idle");
    clear_logs();
    for (int i = 0; i < 10; i++) push_txn(i);
    drive_go();
    wait_idle("reset_restart");
    check_log("reset_restart");
  endtask

  initial begin
    reset = 1'b1;
    go    = 1'b0;
    test_reset();
    test_all_ack();
    test_gap_timing();
    test_nack_retry();
    test_addr_abort();
    test_go_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
